// File: rtl/player_input_conditioner.sv
// player_input_conditioner: synchronises raw per-player pins, debounces
// strobe+data, and latches one choice per player per round with a
// one-cycle capture pulse.
module player_input_conditioner #(
    parameter int unsigned NUM_PLAYERS     = 6,
    parameter int unsigned DATA_W          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PLAYERS*DATA_W-1:0] raw_data,
    input  logic [NUM_PLAYERS-1:0]        raw_strobe,
    input  logic                          clear,
    output logic [NUM_PLAYERS*DATA_W-1:0] choice,
    output logic [NUM_PLAYERS-1:0]        player_clk,
    output logic [NUM_PLAYERS-1:0]        locked
);

    localparam int unsigned BUS_W = NUM_PLAYERS * DATA_W;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } state_t;

    logic [BUS_W-1:0]       r_sync1_data;
    logic [BUS_W-1:0]       r_sync2_data;
    logic [NUM_PLAYERS-1:0] r_sync1_strb;
    logic [NUM_PLAYERS-1:0] r_sync2_strb;

    logic [NUM_PLAYERS-1:0] w_capture;
    logic [BUS_W-1:0]       w_cap_data;
    logic [NUM_PLAYERS-1:0] w_fire;

    logic [BUS_W-1:0]       r_choice;
    logic [NUM_PLAYERS-1:0] r_player_clk;
    logic [NUM_PLAYERS-1:0] r_locked;

    // Two-flop synchroniser on every raw pin
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1_data <= '0;
            r_sync2_data <= '0;
            r_sync1_strb <= '0;
            r_sync2_strb <= '0;
        end else begin
            r_sync1_data <= raw_data;
            r_sync2_data <= r_sync1_data;
            r_sync1_strb <= raw_strobe;
            r_sync2_strb <= r_sync1_strb;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        state_t             r_state;
        state_t             w_state_nxt;
        logic [CNT_W-1:0]   r_cnt;
        logic [CNT_W-1:0]   w_cnt_nxt;
        logic [DATA_W-1:0]  r_snap;
        logic [DATA_W-1:0]  w_snap_nxt;
        logic               w_strb;
        logic [DATA_W-1:0]  w_data;
        logic               w_cap;

        assign w_strb = r_sync2_strb[p];
        assign w_data = r_sync2_data[p*DATA_W +: DATA_W];

        // Debounce state, counter and data snapshot registers
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_snap  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_snap  <= w_snap_nxt;
            end
        end

        // Next-state: strobe and data must hold for DEBOUNCE_CYCLES in RISE,
        // strobe must stay low for DEBOUNCE_CYCLES in FALL before re-arming
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_snap_nxt  = r_snap;
            case (r_state)
                ST_IDLE: begin
                    if (w_strb) begin
                        w_state_nxt = ST_RISE;
                        w_cnt_nxt   = CNT_W'(1);
                        w_snap_nxt  = w_data;
                    end
                end
                ST_RISE: begin
                    if (!w_strb) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_data != r_snap) begin
                        w_cnt_nxt  = CNT_W'(1);
                        w_snap_nxt = w_data;
                    end else if (r_cnt == CNT_MAX) begin
                        w_state_nxt = ST_HIGH;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!w_strb) begin
                        w_state_nxt = ST_FALL;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
                ST_FALL: begin
                    if (w_strb) begin
                        w_state_nxt = ST_HIGH;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_MAX) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // Capture event: the RISE -> HIGH transition
        always_comb begin
            w_cap = 1'b0;
            if (r_state == ST_RISE && w_strb && w_data == r_snap && r_cnt == CNT_MAX) begin
                w_cap = 1'b1;
            end
        end

        assign w_capture[p]                    = w_cap;
        assign w_cap_data[p*DATA_W +: DATA_W]  = r_snap;
    end

    // A capture only counts for a player still unlocked this round
    assign w_fire = w_capture & ~r_locked;

    // Round latch: clear beats any same-cycle capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_choice     <= '0;
            r_player_clk <= '0;
            r_locked     <= '0;
        end else if (clear) begin
            r_choice     <= '0;
            r_player_clk <= '0;
            r_locked     <= '0;
        end else begin
            r_player_clk <= w_fire;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (w_fire[p]) begin
                    r_choice[p*DATA_W +: DATA_W] <= w_cap_data[p*DATA_W +: DATA_W];
                    r_locked[p]                  <= 1'b1;
                end
            end
        end
    end

    assign choice     = r_choice;
    assign player_clk = r_player_clk;
    assign locked     = r_locked;

endmodule
